// File: rtl/oam_dma_ctrl.sv
// Sprite-OAM DMA engine: a CPU write to DMA_REG_ADDR halts the CPU and copies page $xx00-$xxFF into OAM.
// Define OAM_DMA_ALIGN_EN to insert the 2A03 get/put alignment cycle after HALT.
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR = 16'h4014
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_wr_en,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_in,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_data,
    output logic        cpu_halt,
    output logic        oam_dma,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_data_out,
    output logic        busy
);

`ifdef OAM_DMA_ALIGN_EN
    localparam logic ALIGN_EN = 1'b1;
`else
    localparam logic ALIGN_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } state_t;

    state_t     state;
    logic       parity;
    logic [7:0] page;
    logic [7:0] idx;
    logic       trigger;

    assign trigger      = cpu_wr_en && (cpu_addr == DMA_REG_ADDR);
    assign busy         = cpu_halt;
    // Synchronous RAM returns the byte during WRITE, so the data path stays combinational.
    assign oam_data_out = oam_dma ? mem_data : 8'h00;

    // Outputs are registered against the state being entered, so they line up with that state's cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            parity   <= 1'b0;
            page     <= 8'h00;
            idx      <= 8'h00;
            mem_rd   <= 1'b0;
            mem_addr <= 16'h0000;
            oam_dma  <= 1'b0;
            oam_addr <= 8'h00;
            cpu_halt <= 1'b0;
        end else begin
            // NOTE: non-blocking everywhere here; each register sees the pre-edge value of every other one.
            parity  <= ~parity;
            mem_rd  <= 1'b0;
            oam_dma <= 1'b0;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        page     <= cpu_data_in;
                        idx      <= 8'h00;
                        state    <= HALT;
                        cpu_halt <= 1'b1;
                    end
                end
                HALT: begin
                    // Parity 0 now means the next cycle is a put, which cannot carry a read.
                    if (ALIGN_EN && !parity) begin
                        state <= ALIGN;
                    end else begin
                        state    <= READ;
                        mem_rd   <= 1'b1;
                        mem_addr <= {page, idx};
                    end
                end
                ALIGN: begin
                    state    <= READ;
                    mem_rd   <= 1'b1;
                    mem_addr <= {page, idx};
                end
                READ: begin
                    state    <= WRITE;
                    oam_dma  <= 1'b1;
                    oam_addr <= idx;
                end
                WRITE: begin
                    if (idx == 8'hFF) begin
                        state    <= IDLE;
                        cpu_halt <= 1'b0;
                    end else begin
                        idx      <= idx + 8'd1;
                        state    <= READ;
                        mem_rd   <= 1'b1;
                        mem_addr <= {page, idx + 8'd1};
                    end
                end
                default: begin
                    state    <= IDLE;
                    cpu_halt <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl: a cycle-offset model of each transfer plus directed scenarios.
module tb_oam_dma_ctrl;

`ifdef OAM_DMA_ALIGN_EN
    localparam bit ALIGN_ON = 1'b1;
`else
    localparam bit ALIGN_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_wr_en = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_data_in = 8'h00;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data = 8'h00;
    logic        cpu_halt;
    logic        oam_dma;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_data_out;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    oam_dma_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_wr_en    (cpu_wr_en),
        .cpu_addr     (cpu_addr),
        .cpu_data_in  (cpu_data_in),
        .mem_rd       (mem_rd),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .cpu_halt     (cpu_halt),
        .oam_dma      (oam_dma),
        .oam_addr     (oam_addr),
        .oam_data_out (oam_data_out),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ram_byte(input logic [15:0] a);
        if (a[15:8] == 8'h02) return a[7:0] ^ 8'hA5;
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    // Synchronous CPU memory: data appears the cycle after the request.
    always @(posedge clk) begin
        if (mem_rd) mem_data <= ram_byte(mem_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a transfer is k cycles after its trigger; byte i is read at k=2+a+2i and written one cycle later.
    bit          m_valid = 0;
    bit          m_active = 0;
    bit          m_par = 0;
    bit          m_align = 0;
    int          m_k = 0;
    logic [7:0]  m_page = 8'h00;
    logic        e_rd, e_dma, e_halt;
    logic [15:0] e_maddr = 16'h0000;
    logic [7:0]  e_oaddr = 8'h00;
    logic [7:0]  e_odata;

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_valid  = 1;
            m_active = 0;
            m_par    = 0;
            e_maddr  = 16'h0000;
            e_oaddr  = 8'h00;
        end else begin
            if (m_active) begin
                m_k++;
                if (m_k == 514 + int'(m_align)) m_active = 0;
            end else if (cpu_wr_en && cpu_addr == 16'h4014) begin
                m_active = 1;
                m_k      = 1;
                m_page   = cpu_data_in;
                m_align  = ALIGN_ON && m_par;
            end
            m_par = ~m_par;
        end
        e_rd    = 0;
        e_dma   = 0;
        e_odata = 8'h00;
        e_halt  = m_active;
        if (m_active) begin
            int j;
            j = m_k - 2 - int'(m_align);
            if (j >= 0 && j % 2 == 0) begin
                e_rd    = 1;
                e_maddr = {m_page, 8'(j / 2)};
            end else if (j >= 0) begin
                e_dma   = 1;
                e_oaddr = 8'((j - 1) / 2);
                e_odata = ram_byte({m_page, e_oaddr});
            end
        end
    end

    // Per-transfer measurements for the literal expectations.
    int          halt_cnt, pulse_cnt, first_rd_off, off_page;
    int          t_trig;
    logic [15:0] first_ma, last_ma;
    logic [7:0]  first_od, last_od, last_oa;
    logic [7:0]  cur_page;

    always @(negedge clk) begin
        if (m_valid) begin
            check("mem_rd", mem_rd, e_rd);
            check("mem_addr", mem_addr, e_maddr);
            check("oam_dma", oam_dma, e_dma);
            check("oam_addr", oam_addr, e_oaddr);
            check("oam_data_out", oam_data_out, e_odata);
            check("cpu_halt", cpu_halt, e_halt);
            check("busy", busy, e_halt);
        end
        if (cpu_halt) halt_cnt++;
        if (mem_rd) begin
            if (first_rd_off < 0) begin
                first_rd_off = cyc - t_trig;
                first_ma     = mem_addr;
            end
            last_ma = mem_addr;
            if (mem_addr[15:8] != cur_page) off_page++;
        end
        if (oam_dma) begin
            if (pulse_cnt == 0) first_od = oam_data_out;
            pulse_cnt++;
            last_od = oam_data_out;
            last_oa = oam_addr;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_meas(input logic [7:0] p);
        halt_cnt     = 0;
        pulse_cnt    = 0;
        first_rd_off = -1;
        off_page     = 0;
        cur_page     = p;
        t_trig       = cyc;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        cpu_wr_en   = 1'b1;
        cpu_addr    = a;
        cpu_data_in = d;
        step(1);
        cpu_wr_en   = 1'b0;
        cpu_addr    = 16'h0000;
        cpu_data_in = 8'h00;
    endtask

    task automatic trigger(input logic [7:0] p);
        clear_meas(p);
        bus_write(16'h4014, p);
    endtask

    task automatic align_parity(input bit want);
        if (m_par != want) step(1);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 700; i++) begin
            if (!cpu_halt) return;
            step(1);
        end
        check({name, "_timeout"}, 1, 0);
    endtask

    initial begin
        step(2);
        reset = 1'b0;
        check("reset_halt", cpu_halt, 0);
        check("reset_mem_addr", mem_addr, 0);
        check("reset_oam_addr", oam_addr, 0);

        // Even-parity trigger, page 2: no alignment either way.
        align_parity(0);
        trigger(8'h02);
        wait_idle("even");
        check("even_halt_len", halt_cnt, 513);
        check("even_pulses", pulse_cnt, 256);
        check("even_first_rd", first_rd_off, 2);
        check("even_first_ma", first_ma, 16'h0200);
        check("even_last_ma", last_ma, 16'h02FF);
        check("even_first_data", first_od, 8'hA5);
        check("even_last_data", last_od, 8'h5A);
        check("even_last_oa", last_oa, 8'hFF);

        // Odd-parity trigger: alignment cycle only when the feature is built in.
        step(3);
        align_parity(1);
        trigger(8'h02);
        wait_idle("odd");
        check("odd_halt_len", halt_cnt, ALIGN_ON ? 514 : 513);
        check("odd_first_rd", first_rd_off, ALIGN_ON ? 3 : 2);
        check("odd_pulses", pulse_cnt, 256);

        // Second $4014 write mid-transfer is ignored.
        step(2);
        trigger(8'h02);
        step(99);
        bus_write(16'h4014, 8'h07);
        wait_idle("retrig");
        check("retrig_off_page", off_page, 0);
        check("retrig_pulses", pulse_cnt, 256);
        check("retrig_len_ok", (halt_cnt == 513) || (ALIGN_ON && halt_cnt == 514), 1);

        // Reset mid-transfer, then a fresh page-3 transfer from idx 0.
        step(2);
        trigger(8'h03);
        step(49);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("rst_halt", cpu_halt, 0);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_oam_addr", oam_addr, 0);
        check("rst_oam_dma", oam_dma, 0);
        trigger(8'h03);
        wait_idle("p3");
        check("p3_first_ma", first_ma, 16'h0300);
        check("p3_pulses", pulse_cnt, 256);
        check("p3_len_ok", (halt_cnt == 513) || (ALIGN_ON && halt_cnt == 514), 1);

        // Accepted on the first IDLE cycle: page FF right away.
        trigger(8'hFF);
        wait_idle("pff");
        check("pff_first_ma", first_ma, 16'hFF00);
        check("pff_last_ma", last_ma, 16'hFFFF);
        check("pff_last_oa", last_oa, 8'hFF);
        check("pff_off_page", off_page, 0);
        check("pff_pulses", pulse_cnt, 256);

        // Neighbouring addresses must not start a transfer.
        step(2);
        clear_meas(8'h00);
        bus_write(16'h4013, 8'h05);
        bus_write(16'h4015, 8'h05);
        bus_write(16'h2014, 8'h05);
        step(5);
        check("decoy_halt_cnt", halt_cnt, 0);
        check("decoy_rd", first_rd_off, -1);

        step(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/oam_dma_ctrl.md
# oam_dma_ctrl

Sprite-OAM DMA engine that sits directly upstream of the PPU top level and drives its `oam_dma`, `oam_addr` and `oam_data_in` inputs. A CPU write to $4014 with page value P starts the transfer. The block halts the CPU, reads the 256 bytes $P00–$PFF from CPU memory, and writes each byte into OAM addresses 0–255 on alternating cycles, matching 2A03 DMA timing.

## Interface
Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address that triggers a transfer.

Ports:
- clk  in  1  system clock; one clk = one CPU cycle.
- reset  in  1  synchronous, active-high.
- cpu_wr_en  in  1  CPU bus write strobe.
- cpu_addr  in  16  CPU bus address.
- cpu_data_in  in  8  CPU bus write data; the page number is taken from it.
- mem_rd  out  1  read request to CPU memory.
- mem_addr  out  16  read address; {page, idx}.
- mem_data  in  8  read data; valid the clk after mem_rd (synchronous RAM).
- cpu_halt  out  1  stalls the CPU while the transfer runs.
- oam_dma  out  1  OAM write enable toward the PPU.
- oam_addr  out  8  OAM write address.
- oam_data_out  out  8  OAM write data.
- busy  out  1  a transfer is in progress; equals cpu_halt.

## Operation
- Trigger: `cpu_wr_en && cpu_addr == DMA_REG_ADDR` while in IDLE.
  - Latches page ← cpu_data_in.
  - Clears idx to 0.
  - Moves to HALT.
- Triggers seen in any state other than IDLE are ignored. Page and idx stay unchanged.
- Parity flag: 1 bit, cleared by reset, toggles every clk. Parity 0 is a get cycle; parity 1 is a put cycle.
- States:
  - IDLE: all strobes low.
  - HALT: one dummy cycle. Next state is ALIGN if the macro is defined and parity is currently 0 (so the next cycle would be a put); otherwise READ.
  - ALIGN: one dummy cycle, then READ.
  - READ: mem_rd=1, mem_addr={page, idx}. Next state is WRITE.
  - WRITE: oam_dma=1, oam_addr=idx, oam_data_out=mem_data. If idx==8'hFF, go to IDLE; else idx←idx+1 and go to READ.
- idx is 8 bits and increments only in WRITE. It never wraps within a transfer.
- cpu_halt = busy = (state != IDLE).
- Outputs are registered or decoded from state. mem_addr and oam_addr hold their last values when unused. oam_data_out is 0 when oam_dma is low.
- A write to $4014 in the same cycle the last WRITE occurs is ignored, because the state is not IDLE in that cycle.
- Reset mid-transfer: returns to IDLE next clk and all outputs are cleared. OAM keeps the bytes already written; there is no resume.

## Timing
- Reset values: state IDLE, parity 0, page 0, idx 0. All outputs are 0, including mem_addr and oam_addr.
- Trigger accepted at cycle T:
  - HALT is at T+1.
  - First READ is at T+2, or at T+3 when alignment is inserted.
- Each byte takes 2 cycles: read at cycle n, OAM write at n+1.
- Length of cpu_halt high:
  - 513 cycles without alignment.
  - 514 cycles with alignment.
- Final OAM write:
  - T+513 without alignment; IDLE with cpu_halt low from T+514.
  - T+514 with alignment; IDLE with cpu_halt low from T+515.
- A new trigger is accepted on the first IDLE cycle.

## Configuration
- `OAM_DMA_ALIGN_EN` defined: HALT inserts the ALIGN cycle as described, so a transfer is 513 or 514 cycles depending on trigger parity, as on real hardware.
- Not defined: ALIGN is never entered. Every transfer is exactly 513 halted cycles regardless of parity. The parity flag may be optimised away.

## Test plan
- Trigger at even parity, page 8'h02, RAM[$0200+i]=i^8'hA5:
  - 256 oam_dma pulses with oam_addr 0..255 and data i^8'hA5.
  - cpu_halt high for 513 cycles.
  - mem_addr runs $0200..$02FF.
- Trigger at odd parity with OAM_DMA_ALIGN_EN defined: cpu_halt high 514 cycles, first mem_rd at T+3. Same trigger with the macro undefined: 513 cycles, first mem_rd at T+2.
- A second $4014 write with data 8'h07 at T+100 during a page-2 transfer: ignored. All addresses stay $02xx and the length is unchanged.
- Reset asserted at T+50: next clk all outputs are 0 and the state is IDLE. A new trigger with page 8'h03 then runs a full 513/514-cycle transfer from idx 0.
- Writes to $4013, $4015 and $2014 with cpu_wr_en=1: no transfer starts and cpu_halt stays 0.
- Page 8'hFF: mem_addr spans $FF00..$FFFF with no overflow. The last write has oam_addr 8'hFF and is followed by IDLE.
